// File: rtl/key_cond_pkg.sv
// Shared types and sizing helper for the pushbutton conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HELD_DELAY = 2'd1,
    REPEATING  = 2'd2
  } rep_state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: 2-flop sync, debounce, press/release strobes and auto-repeat.
// Debounced level lands STABLE_CYCLES+1 edges after the first sampled change; no backpressure.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic step_o
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = cnt_width(STABLE_CYCLES);
  localparam int TW   = cnt_width(TMAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] DLY_LAST = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic          s1_q, s2_q, key_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          press_d, release_d;
  logic          press_q, release_q, step_q;
  rep_state_t    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rep;

  assign key_s = ~s2_q;

  // Any sample that matches the accepted level restarts the stability count.
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (key_s == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      pressed_d = key_s;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign press_d   = pressed_d & ~pressed_q;
  assign release_d = ~pressed_d & pressed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      s1_q      <= key_n_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= press_d | rep;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Gating on the next debounced level lets a release win over a coinciding repeat.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (!pressed_d) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d && (REPEAT_DELAY != 0)) begin
            state_d = HELD_DELAY;
            tmr_d   = '0;
          end
        end
        HELD_DELAY: begin
          if (tmr_q == DLY_LAST) begin
            state_d = REPEATING;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        REPEATING: begin
          if (tmr_q == PER_LAST) tmr_d = '0;
          else                   tmr_d = tmr_q + TMR_ONE;
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    rep = 1'b0;
    if (pressed_d) begin
      rep = ((state_q == HELD_DELAY) && (tmr_q == DLY_LAST)) ||
            ((state_q == REPEATING)  && (tmr_q == PER_LAST));
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign step_o          = step_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low pushbuttons into debounced levels and one-cycle strobes.
// Each bit comes from an independent key_channel; outputs are registered, no backpressure.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] step
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_channel (
      .clk_i          (CLOCK_50),
      .rst_i          (Reset),
      .key_n_i        (KEY[k]),
      .pressed_o      (pressed[k]),
      .press_pulse_o  (press_pulse[k]),
      .release_pulse_o(release_pulse[k]),
      .step_o         (step[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_key_conditioner;

  localparam int SC   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int NONE = -1000;
  localparam int FAR  = 100000;

  logic       CLOCK_50 = 1'b0;
  logic       Reset;
  logic [3:0] KEY;
  logic [3:0] pressed, press_pulse, release_pulse, step;

  int nvec = 0;
  int nerr = 0;
  int pv[4];
  int rv[4];

  key_conditioner #(
    .N_KEYS       (4),
    .STABLE_CYCLES(SC),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .Reset        (Reset),
    .KEY          (KEY),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step         (step)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Expected {pressed, press_pulse, release_pulse, step} after edge e, given the
  // edge each key's press is accepted (p) and its debounced release lands (r).
  function automatic logic [15:0] expect_at(input int e, input int p[4], input int r[4]);
    logic [3:0] a, b, c, d;
    for (int k = 0; k < 4; k++) begin
      a[k] = (e >= p[k]) && (e < r[k]);
      b[k] = (e == p[k]);
      c[k] = (e == r[k]);
      d[k] = b[k] || ((e >= p[k] + RD) && (e < r[k]) && (((e - p[k] - RD) % RP) == 0));
    end
    return {a, b, c, d};
  endfunction

  task automatic chk(input string tag, input int e, input logic [15:0] exp);
    logic [15:0] obs;
    obs = {pressed, press_pulse, release_pulse, step};
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s edge %0d: observed p/pp/rp/st=%h expected=%h", tag, e, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1;
    KEY   = 4'hF;

    // Reset with all keys released, then quiet idle.
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("reset_hold", i, 16'h0);
    end
    Reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("idle_after_reset", i, 16'h0);
    end

    // Clean press on KEY[1] for 8 edges, then release.
    pv = '{NONE, 6, NONE, NONE};
    rv = '{NONE, 14, NONE, NONE};
    for (int e = 1; e <= 20; e++) begin
      KEY = (e <= 8) ? 4'b1101 : 4'b1111;
      tick();
      chk("clean_press", e, expect_at(e, pv, rv));
    end

    // KEY[2] bounces every 2 edges for 20 edges, holds low for 6, then releases.
    pv = '{NONE, NONE, 26, NONE};
    rv = '{NONE, NONE, 32, NONE};
    for (int e = 1; e <= 40; e++) begin
      KEY = 4'hF;
      if (e <= 20)      KEY[2] = (((e - 1) / 2) % 2) == 1;
      else if (e <= 26) KEY[2] = 1'b0;
      tick();
      chk("bounce", e, expect_at(e, pv, rv));
    end

    // KEY[0] held 40 edges: repeats at P+10, then every 5; release at 46 beats a repeat.
    pv = '{6, NONE, NONE, NONE};
    rv = '{46, NONE, NONE, NONE};
    for (int e = 1; e <= 55; e++) begin
      KEY = (e <= 40) ? 4'b1110 : 4'b1111;
      tick();
      chk("auto_repeat", e, expect_at(e, pv, rv));
    end

    // Reset at P+12 while KEY[0] stays low; press must re-qualify afterwards.
    pv = '{6, NONE, NONE, NONE};
    rv = '{FAR, NONE, NONE, NONE};
    KEY = 4'b1110;
    for (int e = 1; e <= 17; e++) begin
      tick();
      chk("pre_reset_repeat", e, expect_at(e, pv, rv));
    end
    Reset = 1'b1;
    tick();
    chk("reset_mid_repeat", 18, 16'h0);
    Reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk("repress_after_reset", e, expect_at(e, pv, rv));
    end
    Reset = 1'b1;
    KEY   = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("reset_while_held", i, 16'h0);
    end
    Reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("no_release_from_reset", i, 16'h0);
    end

    // KEY[3] and KEY[0] fall together; KEY[3] releases first, repeats stay per-channel.
    pv = '{6, NONE, NONE, 6};
    rv = '{34, NONE, NONE, 24};
    for (int e = 1; e <= 40; e++) begin
      KEY = 4'hF;
      if (e <= 28) KEY[0] = 1'b0;
      if (e <= 18) KEY[3] = 1'b0;
      tick();
      chk("simultaneous", e, expect_at(e, pv, rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
